// File: rtl/ras_checkpoint_queue_if.sv
// Fetch-side bundle between the RAS checkpoint queue and the fetch/commit/recover logic.
// Allocation is a valid/ready transfer on an edge with allocValid && allocReady; commit,
// recover and flushAll are single-cycle commands with no backpressure.
interface ras_checkpoint_queue_if #(
    parameter int CHECKPOINT_NUM = 16,
    parameter int RAS_ENTRY_NUM  = 16,
    parameter int PC_WIDTH       = 32
);
    localparam int RP_W = $clog2(RAS_ENTRY_NUM);
    localparam int ID_W = $clog2(CHECKPOINT_NUM);

    logic                allocValid;
    logic [RP_W-1:0]     allocPtr;
    logic [PC_WIDTH-1:0] allocTop;
    logic                allocReady;
    logic [ID_W-1:0]     allocId;
    logic                commitValid;
    logic                recoverValid;
    logic [ID_W-1:0]     recoverId;
    logic                flushAll;
    logic                restoreValid;
    logic [RP_W-1:0]     restorePtr;
    logic [PC_WIDTH-1:0] restoreTop;
    logic [ID_W:0]       count;
    logic                empty;
    logic                errInvalid;

    modport master (
        output allocValid, allocPtr, allocTop, commitValid, recoverValid, recoverId, flushAll,
        input  allocReady, allocId, restoreValid, restorePtr, restoreTop, count, empty, errInvalid
    );

    modport slave (
        input  allocValid, allocPtr, allocTop, commitValid, recoverValid, recoverId, flushAll,
        output allocReady, allocId, restoreValid, restorePtr, restoreTop, count, empty, errInvalid
    );
endinterface

// File: rtl/ras_checkpoint_queue.sv
// Circular queue of return-address-stack snapshots: allocated per predicted branch,
// released in order at commit, and read back on a misprediction to repair the stack.
module ras_checkpoint_queue #(
    parameter int CHECKPOINT_NUM = 16,
    parameter int RAS_ENTRY_NUM  = 16,
    parameter int PC_WIDTH       = 32
) (
    input  logic                    clk,
    input  logic                    rstN,
    ras_checkpoint_queue_if.slave   cq
);
    localparam int RP_W  = $clog2(RAS_ENTRY_NUM);
    localparam int ID_W  = $clog2(CHECKPOINT_NUM);
    localparam int ENT_W = RP_W + PC_WIDTH;
    localparam logic [ID_W:0] ONE  = (ID_W+1)'(1);
    localparam logic [ID_W:0] FULL = (ID_W+1)'(CHECKPOINT_NUM);

    logic [ID_W:0]       head_q, head_d, tail_q, tail_d;
    logic [ID_W:0]       count_w;
    logic [ID_W-1:0]     rec_rel;
    logic                full_w, empty_w, rec_live;
    logic                do_alloc, do_commit, do_recover;
    logic                rv_q, rv_d, err_q, err_d;
    logic [RP_W-1:0]     rptr_q, rptr_d;
    logic [PC_WIDTH-1:0] rtop_q, rtop_d;
    logic [ENT_W-1:0]    mem_q [CHECKPOINT_NUM];

    always_comb begin
        count_w = tail_q - head_q;
        full_w  = (count_w == FULL);
        empty_w = (count_w == '0);
        // Distance from the oldest entry; the id is live only if it lies inside [head, tail).
        rec_rel  = cq.recoverId - head_q[ID_W-1:0];
        rec_live = ({1'b0, rec_rel} < count_w);

        do_commit  = cq.commitValid && !empty_w && !cq.flushAll;
        do_recover = cq.recoverValid && rec_live && !cq.flushAll;
        do_alloc   = cq.allocValid && !full_w && !cq.flushAll && !cq.recoverValid;

        head_d = head_q;
        tail_d = tail_q;
        if (cq.flushAll) begin
            head_d = tail_q;
        end else begin
            if (do_commit) head_d = head_q + ONE;
            // Rebuilding tail from the pre-cycle head keeps the wrap bit right.
            if (do_recover)    tail_d = head_q + {1'b0, rec_rel} + ONE;
            else if (do_alloc) tail_d = tail_q + ONE;
        end

        rv_d   = do_recover;
        err_d  = !cq.flushAll && ((cq.commitValid && empty_w) || (cq.recoverValid && !rec_live));
        rptr_d = rptr_q;
        rtop_d = rtop_q;
        if (do_recover) {rptr_d, rtop_d} = mem_q[cq.recoverId];
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            head_q <= '0;
            tail_q <= '0;
            rv_q   <= 1'b0;
            err_q  <= 1'b0;
            rptr_q <= '0;
            rtop_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            rv_q   <= rv_d;
            err_q  <= err_d;
            rptr_q <= rptr_d;
            rtop_q <= rtop_d;
        end
    end

    // Snapshot storage needs no reset: only entries inside [head, tail) are ever read.
    always_ff @(posedge clk) begin
        if (do_alloc) mem_q[tail_q[ID_W-1:0]] <= {cq.allocPtr, cq.allocTop};
    end

    assign cq.allocReady   = !full_w;
    assign cq.allocId      = tail_q[ID_W-1:0];
    assign cq.count        = count_w;
    assign cq.empty        = empty_w;
    assign cq.restoreValid = rv_q;
    assign cq.restorePtr   = rptr_q;
    assign cq.restoreTop   = rtop_q;
    assign cq.errInvalid   = err_q;
endmodule

// File: tb/tb_ras_checkpoint_queue.sv
// Directed bench for ras_checkpoint_queue: a queue-based reference of live snapshots,
// a per-cycle compare against it, and literal spot checks on hand-computed values.
module tb_ras_checkpoint_queue;
    localparam int N    = 16;
    localparam int RP_W = 4;
    localparam int PC_W = 32;

    typedef struct packed {
        logic [RP_W-1:0] ptr;
        logic [PC_W-1:0] top;
    } ent_t;

    logic clk;
    logic rstN;
    int   total = 0;
    int   bad   = 0;

    ras_checkpoint_queue_if #(.CHECKPOINT_NUM(N), .RAS_ENTRY_NUM(16), .PC_WIDTH(PC_W)) cq ();

    ras_checkpoint_queue #(.CHECKPOINT_NUM(N), .RAS_ENTRY_NUM(16), .PC_WIDTH(PC_W)) dut (
        .clk  (clk),
        .rstN (rstN),
        .cq   (cq.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    ent_t            exp_q[$];
    int              m_head;
    bit              exp_rv, exp_err;
    logic [RP_W-1:0] exp_rptr;
    logic [PC_W-1:0] exp_rtop;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            exp_q.delete();
            m_head   = 0;
            exp_rv   = 0;
            exp_err  = 0;
            exp_rptr = '0;
            exp_rtop = '0;
        end else begin
            int   sz, off;
            bit   live;
            ent_t e;
            sz   = exp_q.size();
            off  = (int'(cq.recoverId) - m_head + N) % N;
            live = (off < sz);
            exp_rv  = 0;
            exp_err = 0;
            if (cq.flushAll) begin
                m_head = (m_head + sz) % N;
                exp_q.delete();
            end else begin
                if (cq.recoverValid) begin
                    if (live) begin
                        e        = exp_q[off];
                        exp_rv   = 1;
                        exp_rptr = e.ptr;
                        exp_rtop = e.top;
                        while (exp_q.size() > off + 1) void'(exp_q.pop_back());
                    end else begin
                        exp_err = 1;
                    end
                end
                if (cq.commitValid) begin
                    if (sz == 0) exp_err = 1;
                    else begin
                        void'(exp_q.pop_front());
                        m_head = (m_head + 1) % N;
                    end
                end
                if (cq.allocValid && !cq.recoverValid && sz < N)
                    exp_q.push_back({cq.allocPtr, cq.allocTop});
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("count", 64'(cq.count), 64'(exp_q.size()));
        chk("empty", 64'(cq.empty), 64'(exp_q.size() == 0));
        chk("alloc_ready", 64'(cq.allocReady), 64'(exp_q.size() < N));
        chk("alloc_id", 64'(cq.allocId), 64'((m_head + exp_q.size()) % N));
        chk("restore_valid", 64'(cq.restoreValid), 64'(exp_rv));
        chk("err_invalid", 64'(cq.errInvalid), 64'(exp_err));
        if (exp_rv) begin
            chk("restore_ptr", 64'(cq.restorePtr), 64'(exp_rptr));
            chk("restore_top", 64'(cq.restoreTop), 64'(exp_rtop));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        cq.allocValid   = 1'b0;
        cq.allocPtr     = '0;
        cq.allocTop     = '0;
        cq.commitValid  = 1'b0;
        cq.recoverValid = 1'b0;
        cq.recoverId    = '0;
        cq.flushAll     = 1'b0;
    endtask

    task automatic cyc(input bit av, input int ptr, input int top, input bit cv,
                       input bit rv, input int rid, input bit fl);
        cq.allocValid   = av;
        cq.allocPtr     = RP_W'(ptr);
        cq.allocTop     = PC_W'(top);
        cq.commitValid  = cv;
        cq.recoverValid = rv;
        cq.recoverId    = 4'(rid);
        cq.flushAll     = fl;
        @(posedge clk);
        #2;
        idle();
    endtask

    task automatic alloc(input int ptr, input int top); cyc(1, ptr, top, 0, 0, 0, 0); endtask
    task automatic commit();                            cyc(0, 0, 0, 1, 0, 0, 0);     endtask
    task automatic recover(input int rid);              cyc(0, 0, 0, 0, 1, rid, 0);   endtask
    task automatic flush();                             cyc(0, 0, 0, 0, 0, 0, 1);     endtask
    task automatic nop();                               cyc(0, 0, 0, 0, 0, 0, 0);     endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle();
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rstN = 1'b1;
        chk("rst_count", 64'(cq.count), 0);
        chk("rst_empty", 64'(cq.empty), 1);
        chk("rst_ready", 64'(cq.allocReady), 1);
        chk("rst_id", 64'(cq.allocId), 0);
        chk("rst_rv", 64'(cq.restoreValid), 0);
        chk("rst_ptr", 64'(cq.restorePtr), 0);
        chk("rst_top", 64'(cq.restoreTop), 0);
        chk("rst_err", 64'(cq.errInvalid), 0);

        // three allocations, then recover the middle one
        chk("id0", 64'(cq.allocId), 0);
        alloc(1, 'h100);
        chk("id1", 64'(cq.allocId), 1);
        alloc(2, 'h104);
        chk("id2", 64'(cq.allocId), 2);
        alloc(3, 'h108);
        chk("count3", 64'(cq.count), 3);
        recover(1);
        chk("rec1_valid", 64'(cq.restoreValid), 1);
        chk("rec1_ptr", 64'(cq.restorePtr), 2);
        chk("rec1_top", 64'(cq.restoreTop), 'h104);
        chk("rec1_count", 64'(cq.count), 2);
        chk("rec1_id", 64'(cq.allocId), 2);
        nop();
        chk("rec1_pulse_end", 64'(cq.restoreValid), 0);
        flush();
        chk("flush_a", 64'(cq.count), 0);

        // fill to capacity starting at id 2
        for (int i = 0; i < 16; i++) alloc(i, 'h1000 + 4 * i);
        chk("full_count", 64'(cq.count), 16);
        chk("full_ready", 64'(cq.allocReady), 0);
        alloc(9, 'hdead);
        chk("drop_count", 64'(cq.count), 16);
        chk("drop_id", 64'(cq.allocId), 2);
        commit();
        chk("commit_count", 64'(cq.count), 15);
        chk("commit_ready", 64'(cq.allocReady), 1);
        flush();

        // alternate alloc/commit across the wrap
        for (int i = 0; i < 40; i++) begin
            alloc(i % 16, 'h2000 + i);
            chk("alt_count_le2", 64'(cq.count <= 2), 1);
            commit();
        end
        chk("alt_id", 64'(cq.allocId), 10);
        alloc(5, 'h3000);
        alloc(6, 'h3004);
        recover(11);
        chk("wrap_rv", 64'(cq.restoreValid), 1);
        chk("wrap_ptr", 64'(cq.restorePtr), 6);
        chk("wrap_top", 64'(cq.restoreTop), 'h3004);
        chk("wrap_count", 64'(cq.count), 2);
        flush();

        // commit + recover of the head entry in one cycle
        alloc(1, 'h4000);
        alloc(2, 'h4004);
        alloc(3, 'h4008);
        alloc(4, 'h400c);
        chk("cr_count4", 64'(cq.count), 4);
        cyc(0, 0, 0, 1, 1, 12, 0);
        chk("cr_count", 64'(cq.count), 0);
        chk("cr_rv", 64'(cq.restoreValid), 1);
        chk("cr_ptr", 64'(cq.restorePtr), 1);
        chk("cr_top", 64'(cq.restoreTop), 'h4000);

        // recover + alloc in one cycle: alloc dropped
        alloc(8, 'h5100);
        alloc(9, 'h5104);
        alloc(10, 'h5108);
        cyc(1, 7, 'h5000, 0, 1, 13, 0);
        chk("ra_count", 64'(cq.count), 1);
        chk("ra_id", 64'(cq.allocId), 14);
        chk("ra_ptr", 64'(cq.restorePtr), 8);
        chk("ra_top", 64'(cq.restoreTop), 'h5100);
        flush();

        // illegal commit and stale recover
        commit();
        chk("ec_err", 64'(cq.errInvalid), 1);
        chk("ec_count", 64'(cq.count), 0);
        chk("ec_rv", 64'(cq.restoreValid), 0);
        nop();
        chk("ec_err_end", 64'(cq.errInvalid), 0);
        alloc(11, 'h6000);
        alloc(12, 'h6004);
        commit();
        recover(14);
        chk("stale_err", 64'(cq.errInvalid), 1);
        chk("stale_count", 64'(cq.count), 1);
        chk("stale_rv", 64'(cq.restoreValid), 0);
        flush();

        // asynchronous reset mid-stream with a recover pending
        for (int i = 0; i < 5; i++) alloc(i + 1, 'h7000 + 4 * i);
        chk("mr_count5", 64'(cq.count), 5);
        cq.recoverValid = 1'b1;
        cq.recoverId    = 4'd1;
        #1;
        rstN = 1'b0;
        #1;
        chk("mr_count", 64'(cq.count), 0);
        chk("mr_rv", 64'(cq.restoreValid), 0);
        chk("mr_err", 64'(cq.errInvalid), 0);
        chk("mr_id", 64'(cq.allocId), 0);
        chk("mr_ptr", 64'(cq.restorePtr), 0);
        chk("mr_top", 64'(cq.restoreTop), 0);
        idle();
        @(posedge clk);
        #2;
        rstN = 1'b1;
        chk("post_count", 64'(cq.count), 0);
        chk("post_id", 64'(cq.allocId), 0);
        for (int i = 0; i < 7; i++) alloc(i, 'h8000 + i);
        chk("fl_count7", 64'(cq.count), 7);
        flush();
        chk("fl_count0", 64'(cq.count), 0);
        nop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
